// File: rtl/ecc_enc_stream.sv
// Streaming SECDED encoder: per-beat code mode, Hamming + overall parity,
// two-stage valid/ready pipeline with an emitted-word counter.
module ecc_enc_stream #(
  parameter int MAX_CODEWORD_WIDTH = 32,
  parameter int MAX_INFO_WIDTH     = 26,
  parameter int CNT_WIDTH          = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [MAX_INFO_WIDTH-1:0]     in_data,
  input  logic [1:0]                    in_mod,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [MAX_CODEWORD_WIDTH-1:0] out_data,
  output logic [1:0]                    out_mod,
  output logic                          out_err,
  output logic [CNT_WIDTH-1:0]          word_cnt
);

  localparam int MAX_PARITY_WIDTH = MAX_CODEWORD_WIDTH - MAX_INFO_WIDTH;
  localparam int CW               = MAX_CODEWORD_WIDTH;

  // n is always a compile-time constant at the call sites, so the loops
  // collapse into a fixed XOR network per supported code size.
  function automatic logic [CW-1:0] encode(input logic [MAX_INFO_WIDTH-1:0] d,
                                           input int n);
    int                          r;
    int                          k;
    logic [MAX_INFO_WIDTH-1:0]   rem;
    logic [MAX_PARITY_WIDTH-1:0] p;
    logic                        ovr;
    logic                        tot;
    logic                        b;
    logic [63:0]                 mask;
    int                          used;
    r    = (n == 8) ? 4 : (n == 16) ? 5 : 6;
    k    = n - r;
    rem  = d;
    p    = '0;
    ovr  = 1'b0;
    used = 0;
    for (int pos = 3; pos < CW; pos++) begin
      if (pos < n && (pos & (pos - 1)) != 0 && used < k) begin
        b   = rem[0];
        rem = rem >> 1;
        ovr = ovr ^ b;
        for (int j = 0; j < MAX_PARITY_WIDTH; j++) begin
          if (j < r - 1 && ((pos >> j) & 1) != 0)
            p[j] = p[j] ^ b;
        end
        used = used + 1;
      end
    end
    // overall parity covers info plus the Hamming bits, landing in the top parity slot
    tot = ovr ^ (^p);
    for (int j = 0; j < MAX_PARITY_WIDTH; j++) begin
      if (j == r - 1)
        p[j] = tot;
    end
    mask = (64'd1 << k) - 64'd1;
    return ((CW'(d) & CW'(mask)) << r) | CW'(p);
  endfunction

  // stage A
  logic                      a_vld;
  logic [MAX_INFO_WIDTH-1:0] a_data;
  logic [1:0]                a_mod;

  // handshake
  logic b_load;
  logic a_adv;
  logic out_fire;

  assign out_fire = out_valid & out_ready;
  assign b_load   = ~out_valid | out_ready;
  assign a_adv    = a_vld & b_load;
  assign in_ready = ~rst & (~a_vld | a_adv);

  // per-size codewords; sizes beyond the output width are never built
  logic [CW-1:0] code8;
  logic [CW-1:0] code16;
  logic [CW-1:0] code32;

  assign code8 = encode(a_data, 8);

  generate
    if (CW >= 16) begin : g_c16
      assign code16 = encode(a_data, 16);
    end else begin : g_n16
      assign code16 = '0;
    end
    if (CW >= 32) begin : g_c32
      assign code32 = encode(a_data, 32);
    end else begin : g_n32
      assign code32 = '0;
    end
  endgenerate

  logic [CW-1:0] a_code;
  logic          a_err;

  always_comb begin
    a_code = '0;
    a_err  = 1'b0;
    case (a_mod)
      2'b00: a_code = code8;
      2'b01: begin
        if (CW >= 16) a_code = code16;
        else          a_err  = 1'b1;
      end
      2'b10: begin
        if (CW >= 32) a_code = code32;
        else          a_err  = 1'b1;
      end
      default: a_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_vld     <= 1'b0;
      a_data    <= '0;
      a_mod     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mod   <= '0;
      out_err   <= 1'b0;
      word_cnt  <= '0;
    end else begin
      if (in_ready) begin
        a_vld <= in_valid;
        if (in_valid) begin
          a_data <= in_data;
          a_mod  <= in_mod;
        end
      end
      if (b_load) begin
        out_valid <= a_vld;
        if (a_vld) begin
          out_data <= a_code;
          out_mod  <= a_mod;
          out_err  <= a_err;
        end
      end
      if (out_fire)
        word_cnt <= word_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_ecc_enc_stream.sv
// Directed + randomized bench for ecc_enc_stream against a positional-XOR
// reference model and an in-order scoreboard.
module tb_ecc_enc_stream;

  localparam int CW   = 32;
  localparam int IW   = 26;
  localparam int CNTW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [IW-1:0]   in_data;
  logic [1:0]      in_mod;
  logic            out_valid;
  logic            out_ready;
  logic [CW-1:0]   out_data;
  logic [1:0]      out_mod;
  logic            out_err;
  logic [CNTW-1:0] word_cnt;

  ecc_enc_stream #(
    .MAX_CODEWORD_WIDTH(CW),
    .MAX_INFO_WIDTH(IW),
    .CNT_WIDTH(CNTW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_mod(in_mod),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_mod(out_mod),
    .out_err(out_err),
    .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] d;
    logic [1:0]    m;
    logic          e;
  } exp_t;

  exp_t            q[$];
  int              passed = 0;
  int              total  = 0;
  logic [CNTW-1:0] cnt_m  = '0;
  logic            hold_v = 1'b0;
  logic [CW-1:0]   hold_d;
  logic [1:0]      hold_m;
  logic            hold_e;

  // Syndrome view: the Hamming bits are the XOR of the position numbers of
  // all set info bits; overall parity makes the whole codeword even.
  function automatic logic [CW-1:0] ref_enc(input logic [IW-1:0] d,
                                            input logic [1:0] m,
                                            output logic err);
    int n, r, k, syn, ones, i, pos;
    logic [CW-1:0] info;
    case (m)
      2'd0:    n = 8;
      2'd1:    n = 16;
      2'd2:    n = 32;
      default: n = 0;
    endcase
    err = (n == 0) || (n > CW);
    if (err) return '0;
    r = $clog2(n) + 1;
    k = n - r;
    syn = 0; ones = 0; i = 0; pos = 3;
    while (i < k) begin
      if ((pos & (pos - 1)) != 0) begin
        if (d[i]) begin
          syn  = syn ^ pos;
          ones = ones + 1;
        end
        i = i + 1;
      end
      pos = pos + 1;
    end
    ones = ones + $countones(syn);
    info = CW'(d) & ((CW'(1) << k) - CW'(1));
    return (info << r) | CW'(syn) | (CW'(ones & 1) << (r - 1));
  endfunction

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock: drive before the edge, sample/score at negedge+1.
  task automatic cycle(input logic v, input logic [IW-1:0] d, input logic [1:0] m,
                       input logic ordy, output logic acc, output logic ov,
                       output logic [CW-1:0] od);
    exp_t e;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_mod    = m;
    out_ready = ordy;
    #1;
    ov  = out_valid;
    od  = out_data;
    acc = v && in_ready;
    if (hold_v) begin
      chk("hold_valid", CW'(out_valid), 1);
      chk("hold_data", out_data, hold_d);
      chk("hold_mod", CW'(out_mod), CW'(hold_m));
      chk("hold_err", CW'(out_err), CW'(hold_e));
    end
    hold_v = out_valid && !ordy;
    hold_d = out_data;
    hold_m = out_mod;
    hold_e = out_err;
    chk("in_ready", CW'(in_ready), CW'((q.size() < 2) || ordy));
    chk("word_cnt", CW'(word_cnt), CW'(cnt_m));
    if (out_valid && ordy) begin
      if (q.size() == 0) begin
        chk("extra_beat", 1, 0);
      end else begin
        e = q.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_mod", CW'(out_mod), CW'(e.m));
        chk("out_err", CW'(out_err), CW'(e.e));
      end
      cnt_m = cnt_m + 1'b1;
    end
    if (acc) begin
      e.d = ref_enc(d, m, e.e);
      e.m = m;
      q.push_back(e);
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    chk("rst_out_valid", CW'(out_valid), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_mod", CW'(out_mod), 0);
    chk("rst_out_err", CW'(out_err), 0);
    chk("rst_word_cnt", CW'(word_cnt), 0);
    chk("rst_in_ready", CW'(in_ready), 0);
    q.delete();
    cnt_m  = '0;
    hold_v = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    logic a, v;
    logic [CW-1:0] o;
    int t;
    t = 0;
    while (q.size() > 0 && t < 20) begin
      cycle(1'b0, '0, 2'b00, 1'b1, a, v, o);
      t++;
    end
    chk("drain_empty", CW'(q.size()), 0);
  endtask

  initial begin
    logic          acc, ov;
    logic [CW-1:0] od;
    logic [7:0]    seq;
    logic [IW-1:0] vd[4];
    logic [1:0]    vm[4];
    logic          pv;
    logic [IW-1:0] pd;
    logic [1:0]    pm;
    int            nacc;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mod = '0; out_ready = 1'b0;
    do_reset(2);

    // latency: one beat, unstalled
    cycle(1'b1, IW'('hB), 2'b00, 1'b1, acc, ov, od);
    chk("lat_acc", CW'(acc), 1);
    chk("lat_c0", CW'(ov), 0);
    cycle(1'b0, '0, 2'b00, 1'b1, acc, ov, od);
    chk("lat_c1", CW'(ov), 0);
    cycle(1'b0, '0, 2'b00, 1'b1, acc, ov, od);
    chk("lat_c2", CW'(ov), 1);
    chk("lat_data", od, 32'h000000B1);
    @(posedge clk); #1;
    chk("lat_cnt", CW'(word_cnt), 1);

    // back-to-back mixed modes
    vd[0] = IW'('hB);   vm[0] = 2'b00;
    vd[1] = IW'('h7FF); vm[1] = 2'b01;
    vd[2] = IW'(1);     vm[2] = 2'b10;
    vd[3] = IW'('hB);   vm[3] = 2'b00;
    seq = '0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, vd[i], vm[i], 1'b1, acc, ov, od);
      chk("b2b_acc", CW'(acc), 1);
      seq = {seq[6:0], ov};
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, 2'b00, 1'b1, acc, ov, od);
      seq = {seq[6:0], ov};
    end
    chk("b2b_ovseq", CW'(seq), 32'h3C);

    // illegal mode and all-zero info
    cycle(1'b1, IW'($urandom), 2'b11, 1'b1, acc, ov, od);
    cycle(1'b1, '0, 2'b10, 1'b1, acc, ov, od);
    drain();

    // backpressure: source holds an unaccepted beat
    pv = 1'b0; pd = '0; pm = '0; nacc = 0;
    for (int i = 0; i < 5; i++) begin
      if (!pv) begin
        pv = 1'b1; pd = IW'($urandom); pm = 2'($urandom_range(0, 2));
      end
      cycle(1'b1, pd, pm, 1'b0, acc, ov, od);
      if (acc) begin
        nacc++;
        pv = 1'b0;
      end
    end
    chk("bp_accepts", CW'(nacc), 2);
    drain();

    // randomized traffic with random backpressure
    pv = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!pv && ($urandom_range(0, 3) != 0)) begin
        pv = 1'b1; pd = IW'($urandom); pm = 2'($urandom_range(0, 3));
      end
      cycle(pv, pd, pm, 1'($urandom_range(0, 9) < 7), acc, ov, od);
      if (acc) pv = 1'b0;
    end
    drain();

    // reset with both stages full
    cycle(1'b1, IW'($urandom), 2'b00, 1'b0, acc, ov, od);
    cycle(1'b1, IW'($urandom), 2'b01, 1'b0, acc, ov, od);
    cycle(1'b1, IW'($urandom), 2'b10, 1'b0, acc, ov, od);
    chk("full_blocked", CW'(acc), 0);
    do_reset(1);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, IW'($urandom), 2'(i), 1'b1, acc, ov, od);
    drain();

    // counter wrap: 17 words on a 4-bit counter
    do_reset(1);
    for (int i = 0; i < 17; i++)
      cycle(1'b1, IW'($urandom), 2'($urandom_range(0, 3)), 1'b1, acc, ov, od);
    drain();
    @(posedge clk); #1;
    chk("wrap_cnt", CW'(word_cnt), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ecc_enc_stream.md
Name: ecc_enc_stream

Overview:
- Streaming, parametrised successor to the stage-1 SECDED encoder.
- Accepts one info word per beat with a per-beat code mode, computes Hamming parity plus overall parity, and emits a zero-padded codeword.
- Uses a 2-stage valid/ready pipeline with full throughput and backpressure, and counts emitted words.
- Sits between the host data interface and the channel/noise stage of the ECC datapath.

Parameters:
- MAX_CODEWORD_WIDTH, 32: output width; must be 8, 16 or 32.
- MAX_INFO_WIDTH, 26: input width; must equal the info width of the largest code.
- CNT_WIDTH, 16: width of the emitted-word counter.
- Derived localparam MAX_PARITY_WIDTH = MAX_CODEWORD_WIDTH - MAX_INFO_WIDTH.

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous reset, active-high.
- in_valid, input, 1: input beat valid.
- in_ready, output, 1: block can accept a beat.
- in_data, input, MAX_INFO_WIDTH: info word; bits above k are ignored.
- in_mod, input, 2: code mode for this beat.
- out_valid, output, 1: codeword valid.
- out_ready, input, 1: downstream accepts.
- out_data, output, MAX_CODEWORD_WIDTH: codeword.
- out_mod, output, 2: mode travelling with the codeword.
- out_err, output, 1: beat carried an illegal or unsupported mode.
- word_cnt, output, CNT_WIDTH: number of codewords handed off.

Behaviour:
- Reset: clk and rst are as declared (synchronous, active-high). While rst is high, every output register is zeroed at each clock edge: out_valid=0, out_data=0, out_mod=0, out_err=0, word_cnt=0. Both pipeline stages are emptied and in-flight beats are discarded. in_ready=0 while rst is high.
- Modes (n / k / r = codeword / info / parity widths):
  - 00 = 8 / 4 / 4.
  - 01 = 16 / 11 / 5.
  - 10 = 32 / 26 / 6.
  - 11 is illegal.
  - A mode whose n exceeds MAX_CODEWORD_WIDTH is also illegal.
- Parity computation:
  - Place info bit i at the i-th non-power-of-two position in 1..n-1, in ascending order (info bit 0 goes to position 3).
  - For j = 0..r-2: p[j] = XOR of the info bits whose position has bit j set.
  - p[r-1] = XOR of all k info bits and p[0..r-2] (overall even parity).
- Codeword format: out_data = {(MAX_CODEWORD_WIDTH - n) zeros, info[k-1:0], p[r-1:0]}.
- Illegal mode: out_data = 0, out_err = 1. The beat still flows through and is still counted.
- Pipeline:
  - Stage A registers in_data and in_mod.
  - Stage B registers the codeword, mode and err; stage B drives the out_* ports.
  - A beat transfers on in_valid & in_ready. The output handshake completes on out_valid & out_ready.
- Latency: an accepted beat appears on out_valid 2 cycles later when there is no backpressure.
- Throughput: 1 beat per cycle.
- Stall rules:
  - Stage B loads when it is empty or being consumed this cycle.
  - Stage A loads when it is empty or moving to B this cycle.
  - in_ready = !rst & (stage A empty | stage A advancing).
  - No beat is ever dropped or duplicated.
  - out_data, out_mod and out_err hold stable while out_valid=1 & out_ready=0.
- Mode is per beat: consecutive beats of different modes are legal and need no bubble.
- word_cnt increments on every out_valid & out_ready and wraps from all-ones to 0.
- in_valid without in_ready: the beat is not taken. The source must hold it.
- Simultaneous input accept and output consume with both stages full: all stages shift, and occupancy is unchanged.
- Reset mid-stream: the pipeline is flushed, and the first beat accepted after reset is the first beat emitted.

Test Plan:
- Mode 00, in_data=26'h00000B, out_ready=1 → 2 cycles later out_data=32'h000000B1, out_err=0, word_cnt=1.
- Mode 01, in_data=26'h0007FF → out_data=32'h0000FFFF. Mode 10, in_data=26'h0000001 → out_data=32'h00000063. Mode 10, in_data=0 → out_data=0.
- Mode 11, any data → out_data=0, out_err=1, out_mod=2'b11, word_cnt increments.
- Back-to-back beats of modes 00, 01, 10, 00 (the first three vectors above, repeated) with out_ready=1 → 4 consecutive out_valid cycles, outputs in order, in_ready held at 1.
- Hold out_ready=0 for 5 cycles while in_valid=1 → in_ready drops after 2 beats are accepted and out_data is stable. Release out_ready → all beats emerge in order with no loss.
- Assert rst with both stages full → the next cycle has out_valid=0 and word_cnt=0. Beats sent after reset emerge in order. With CNT_WIDTH=4, 17 beats give word_cnt=1 (wrap).
